// File: rtl/sdram_pkg.sv
// Shared types for the SDRAM port arbiter: slot contents, widths and FSM states.
package sdram_pkg;

  localparam int unsigned ADDR_W = 22;
  localparam int unsigned DATA_W = 16;

  typedef struct packed {
    logic              we;
    logic [1:0]        wm;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data_write;
  } sdram_slot_t;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StRefresh
  } arb_state_e;

  localparam logic [1:0] OwedMax = 2'd3;

endpackage

// File: rtl/sdram_arbiter_rr_picker.sv
// Combinational round-robin picker: one-hot grant of the first requester after last_i.
module rr_picker #(
  parameter int unsigned Width = 3,
  parameter int unsigned IdxW  = (Width > 1) ? $clog2(Width) : 1
) (
  input  logic [Width-1:0] req_i,
  input  logic [IdxW-1:0]  last_i,
  output logic [Width-1:0] gnt_o,
  output logic             any_o
);

  always_comb begin
    int unsigned idx;
    logic        found;
    gnt_o = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned off = 1; off <= Width; off++) begin
      idx = (32'(last_i) + off) % Width;
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/sdram_arbiter.sv
// Shares one SDRAM controller port between pulse requesters and schedules auto-refresh.
module sdram_arbiter
  import sdram_pkg::*;
#(
  parameter int unsigned NUM_PORTS        = 2,
  parameter int unsigned ADDR_W           = sdram_pkg::ADDR_W,
  parameter int unsigned REFRESH_INTERVAL = 780,
  parameter int unsigned REFRESH_URGENT   = 2
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_PORTS-1:0]        p_req,
  input  logic [NUM_PORTS-1:0]        p_we,
  input  logic [2*NUM_PORTS-1:0]      p_wm,
  input  logic [ADDR_W*NUM_PORTS-1:0] p_address,
  input  logic [DATA_W*NUM_PORTS-1:0] p_data_write,
  input  logic [NUM_PORTS-1:0]        p_refresh_hint,
  output logic [NUM_PORTS-1:0]        p_ack,
  output logic [DATA_W-1:0]           p_data_read,
  output logic [NUM_PORTS-1:0]        p_overflow,
  output logic                        mem_req,
  output logic                        mem_refresh,
  output logic                        mem_we,
  output logic [1:0]                  mem_wm,
  output logic [ADDR_W-1:0]           mem_address,
  output logic [DATA_W-1:0]           mem_data_write,
  input  logic                        mem_ack,
  input  logic [DATA_W-1:0]           mem_data_read
);

  localparam int unsigned RrW      = (NUM_PORTS > 1) ? NUM_PORTS - 1 : 1;
  localparam int unsigned RrIdxW   = (RrW > 1) ? $clog2(RrW) : 1;
  localparam int unsigned PortIdxW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int unsigned CntW     = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;

  arb_state_e           state_q, state_d;
  sdram_slot_t          slot_q [NUM_PORTS];
  logic [NUM_PORTS-1:0] pending_q, pending_d;
  logic [NUM_PORTS-1:0] overflow_q, overflow_d;
  logic [CntW-1:0]      refresh_cnt_q, refresh_cnt_d;
  logic [1:0]           owed_q, owed_d;
  logic                 hint_q, hint_d;
  logic [PortIdxW-1:0]  gnt_q, gnt_d;
  logic [RrIdxW-1:0]    last_rr_q, last_rr_d;

  logic                 mem_req_q, mem_refresh_q, mem_we_q;
  logic [1:0]           mem_wm_q;
  logic [ADDR_W-1:0]    mem_address_q;
  logic [DATA_W-1:0]    mem_data_write_q, p_data_read_q;
  logic [NUM_PORTS-1:0] p_ack_q;

  logic                 wrap, urgent, ack_done, ref_done;
  logic                 issue_req, issue_ref;
  logic [PortIdxW-1:0]  issue_port;
  logic [RrW-1:0]       rr_gnt;
  logic                 rr_any;
  logic [RrIdxW-1:0]    rr_idx;

  assign wrap     = refresh_cnt_q == CntW'(REFRESH_INTERVAL - 1);
  assign urgent   = 32'(owed_q) >= REFRESH_URGENT;
  assign ack_done = (state_q == StBusy) && mem_ack;
  assign ref_done = (state_q == StRefresh) && mem_ack;

  rr_picker #(
    .Width (RrW),
    .IdxW  (RrIdxW)
  ) u_rr_picker (
    .req_i  (pending_q[NUM_PORTS-1:NUM_PORTS-RrW]),
    .last_i (last_rr_q),
    .gnt_o  (rr_gnt),
    .any_o  (rr_any)
  );

  always_comb begin
    rr_idx = '0;
    for (int unsigned k = 0; k < RrW; k++) begin
      if (rr_gnt[k]) rr_idx = RrIdxW'(k);
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_rr_d  = last_rr_q;
    issue_req  = 1'b0;
    issue_ref  = 1'b0;
    issue_port = '0;
    case (state_q)
      StIdle: begin
        if (urgent) begin
          issue_ref = 1'b1;
        end else if (pending_q[0]) begin
          issue_req = 1'b1;
        end else if (owed_q != 2'd0) begin
          issue_ref = 1'b1;
        end else if (rr_any && NUM_PORTS > 1) begin
          issue_req  = 1'b1;
          issue_port = PortIdxW'(32'(rr_idx) + 1);
          last_rr_d  = rr_idx;
        end else if (hint_q) begin
          issue_ref = 1'b1;
        end
        if (issue_req) begin
          state_d = StBusy;
          gnt_d   = issue_port;
        end else if (issue_ref) begin
          state_d = StRefresh;
        end
      end
      StBusy:    if (mem_ack) state_d = StIdle;
      StRefresh: if (mem_ack) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Clear on completion first so a same-edge re-request is a fresh capture, not an overflow.
  always_comb begin
    pending_d  = pending_q;
    overflow_d = overflow_q;
    if (ack_done) pending_d[gnt_q] = 1'b0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (p_req[i]) begin
        if (pending_d[i]) overflow_d[i] = 1'b1;
        pending_d[i] = 1'b1;
      end
    end
  end

  always_comb begin
    refresh_cnt_d = wrap ? '0 : refresh_cnt_q + 1'b1;
    owed_d        = owed_q;
    if (ref_done && owed_d != 2'd0) owed_d = owed_d - 2'd1;
    if (wrap && owed_d != OwedMax)  owed_d = owed_d + 2'd1;
    hint_d = hint_q;
    if (ref_done)         hint_d = 1'b0;
    if (|p_refresh_hint)  hint_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= StIdle;
      pending_q        <= '0;
      overflow_q       <= '0;
      refresh_cnt_q    <= '0;
      owed_q           <= '0;
      hint_q           <= 1'b0;
      gnt_q            <= '0;
      last_rr_q        <= RrIdxW'(RrW - 1);
      mem_req_q        <= 1'b0;
      mem_refresh_q    <= 1'b0;
      mem_we_q         <= 1'b0;
      mem_wm_q         <= '0;
      mem_address_q    <= '0;
      mem_data_write_q <= '0;
      p_data_read_q    <= '0;
      p_ack_q          <= '0;
      for (int unsigned i = 0; i < NUM_PORTS; i++) slot_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      overflow_q    <= overflow_d;
      refresh_cnt_q <= refresh_cnt_d;
      owed_q        <= owed_d;
      hint_q        <= hint_d;
      gnt_q         <= gnt_d;
      last_rr_q     <= last_rr_d;
      mem_req_q     <= issue_req;
      mem_refresh_q <= issue_ref;
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
        if (p_req[i]) begin
          slot_q[i] <= '{we:         p_we[i],
                         wm:         p_wm[2*i +: 2],
                         address:    p_address[ADDR_W*i +: ADDR_W],
                         data_write: p_data_write[DATA_W*i +: DATA_W]};
        end
      end
      // The in-flight copy lets the slot be re-captured while its access is outstanding.
      if (issue_req) begin
        mem_we_q         <= slot_q[issue_port].we;
        mem_wm_q         <= slot_q[issue_port].wm;
        mem_address_q    <= slot_q[issue_port].address;
        mem_data_write_q <= slot_q[issue_port].data_write;
      end
      p_ack_q <= '0;
      if (ack_done) begin
        p_ack_q[gnt_q] <= 1'b1;
        if (!mem_we_q) p_data_read_q <= mem_data_read;
      end
    end
  end

  assign p_ack          = p_ack_q;
  assign p_data_read    = p_data_read_q;
  assign p_overflow     = overflow_q;
  assign mem_req        = mem_req_q;
  assign mem_refresh    = mem_refresh_q;
  assign mem_we         = mem_we_q;
  assign mem_wm         = mem_wm_q;
  assign mem_address    = mem_address_q;
  assign mem_data_write = mem_data_write_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter with a small delayed-ack controller model.
module tb_sdram_arbiter;

  localparam int NP = 4;
  localparam int AW = 22;
  localparam int RI = 64;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [NP-1:0]    p_req, p_we, p_refresh_hint;
  logic [2*NP-1:0]  p_wm;
  logic [AW*NP-1:0] p_address;
  logic [16*NP-1:0] p_data_write;
  logic [NP-1:0]    p_ack, p_overflow;
  logic [15:0]      p_data_read;
  logic             mem_req, mem_refresh, mem_we, mem_ack;
  logic [1:0]       mem_wm;
  logic [AW-1:0]    mem_address;
  logic [15:0]      mem_data_write, mem_data_read;

  int n_tests = 0;
  int n_fail  = 0;

  sdram_arbiter #(
    .NUM_PORTS        (NP),
    .ADDR_W           (AW),
    .REFRESH_INTERVAL (RI),
    .REFRESH_URGENT   (2)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .p_req          (p_req),
    .p_we           (p_we),
    .p_wm           (p_wm),
    .p_address      (p_address),
    .p_data_write   (p_data_write),
    .p_refresh_hint (p_refresh_hint),
    .p_ack          (p_ack),
    .p_data_read    (p_data_read),
    .p_overflow     (p_overflow),
    .mem_req        (mem_req),
    .mem_refresh    (mem_refresh),
    .mem_we         (mem_we),
    .mem_wm         (mem_wm),
    .mem_address    (mem_address),
    .mem_data_write (mem_data_write),
    .mem_ack        (mem_ack),
    .mem_data_read  (mem_data_read)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int t0  = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Controller model: mem_ack arrives ack_dly cycles after the request cycle.
  int          ack_dly = 3;
  bit          rsp_en  = 1'b1;
  logic [15:0] rd_data = '0;
  int          rsp_cnt;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_ack       <= 1'b0;
      mem_data_read <= '0;
      rsp_cnt       <= 0;
    end else begin
      mem_ack <= 1'b0;
      if ((mem_req || mem_refresh) && rsp_en) begin
        rsp_cnt <= ack_dly - 1;
      end else if (rsp_cnt != 0) begin
        rsp_cnt <= rsp_cnt - 1;
        if (rsp_cnt == 1) begin
          mem_ack       <= 1'b1;
          mem_data_read <= rd_data;
        end
      end
    end
  end

  typedef struct {
    bit          is_ref;
    logic [21:0] addr;
    logic        we;
    logic [15:0] data;
    int          t;
  } ev_t;

  ev_t ev_q[$];
  int  ack_q[$];

  always @(negedge clk) begin
    if (mem_req)
      ev_q.push_back('{is_ref: 1'b0, addr: mem_address, we: mem_we, data: mem_data_write, t: cyc});
    if (mem_refresh)
      ev_q.push_back('{is_ref: 1'b1, addr: '0, we: 1'b0, data: '0, t: cyc});
    for (int i = 0; i < NP; i++) if (p_ack[i]) ack_q.push_back(i);
  end

  task automatic clear_inputs();
    p_req = '0; p_we = '0; p_wm = '0; p_address = '0; p_data_write = '0; p_refresh_hint = '0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    clear_inputs();
    rsp_en  = 1'b1;
    ack_dly = 3;
    rd_data = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    t0 = cyc;
    ev_q.delete();
    ack_q.delete();
  endtask

  task automatic set_port(input int p, input logic we, input logic [21:0] a,
                          input logic [15:0] d);
    p_req[p]               = 1'b1;
    p_we[p]                = we;
    p_wm[2*p +: 2]         = 2'b00;
    p_address[AW*p +: AW]  = a;
    p_data_write[16*p +: 16] = d;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    n_tests++; if (p_ack !== '0) begin n_fail++;
      $display("FAIL reset_p_ack got %h want 0", p_ack); end
    n_tests++; if (p_overflow !== '0) begin n_fail++;
      $display("FAIL reset_overflow got %h want 0", p_overflow); end
    n_tests++; if ({mem_req, mem_refresh} !== 2'b00) begin n_fail++;
      $display("FAIL reset_mem_strobes got %b want 00", {mem_req, mem_refresh}); end
    n_tests++; if ({mem_we, mem_wm, mem_address, mem_data_write} !== '0) begin n_fail++;
      $display("FAIL reset_mem_fields got %h want 0", {mem_we, mem_wm, mem_address}); end
    n_tests++; if (p_data_read !== 16'h0) begin n_fail++;
      $display("FAIL reset_data_read got %h want 0", p_data_read); end
    do_reset();
    repeat (4) @(negedge clk);
    n_tests++; if (ev_q.size() != 0) begin n_fail++;
      $display("FAIL reset_idle_quiet got %0d events want 0", ev_q.size()); end
  endtask

  task automatic test_single_read();
    int n = 0;
    int lat = -1;
    do_reset();
    rd_data = 16'hBEEF;
    set_port(1, 1'b0, 22'h000123, 16'h0);
    @(negedge clk);
    p_req = '0;
    n_tests++; if (mem_req !== 1'b0) begin n_fail++;
      $display("FAIL read_early_req got %b want 0", mem_req); end
    @(negedge clk);
    n_tests++; if (mem_req !== 1'b1) begin n_fail++;
      $display("FAIL read_req got %b want 1", mem_req); end
    n_tests++; if ({mem_we, mem_address} !== {1'b0, 22'h000123}) begin n_fail++;
      $display("FAIL read_fields got we=%b addr=%h want we=0 addr=000123", mem_we, mem_address); end
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (p_ack[1]) begin
        n++;
        if (lat < 0) lat = i;
      end
    end
    n_tests++; if (n != 1) begin n_fail++;
      $display("FAIL read_ack_count got %0d want 1", n); end
    n_tests++; if (lat != 4) begin n_fail++;
      $display("FAIL read_ack_latency got %0d want 4", lat); end
    n_tests++; if (p_data_read !== 16'hBEEF) begin n_fail++;
      $display("FAIL read_data got %h want beef", p_data_read); end
  endtask

  task automatic test_priority();
    do_reset();
    ack_dly = 2;
    set_port(0, 1'b1, 22'h100, 16'h1111);
    set_port(1, 1'b1, 22'h200, 16'h2222);
    @(negedge clk);
    p_req = '0;
    repeat (15) @(negedge clk);
    n_tests++; if (ev_q.size() != 2) begin n_fail++;
      $display("FAIL prio_req_count got %0d want 2", ev_q.size()); end
    n_tests++;
    if (ev_q.size() < 1 || {ev_q[0].addr, ev_q[0].data} !== {22'h100, 16'h1111}) begin
      n_fail++; $display("FAIL prio_first got addr=%h data=%h want 100/1111",
                         ev_q[0].addr, ev_q[0].data); end
    n_tests++;
    if (ev_q.size() < 2 || {ev_q[1].addr, ev_q[1].data} !== {22'h200, 16'h2222}) begin
      n_fail++; $display("FAIL prio_second got addr=%h data=%h want 200/2222",
                         ev_q[1].addr, ev_q[1].data); end
    n_tests++;
    if (ack_q.size() != 2 || ack_q[0] != 0 || ack_q[1] != 1) begin
      n_fail++; $display("FAIL prio_ack_order got size=%0d want acks 0 then 1", ack_q.size()); end
  endtask

  task automatic test_round_robin();
    logic [21:0] exp_addr [6];
    exp_addr[0] = 22'h1; exp_addr[1] = 22'h2; exp_addr[2] = 22'h3;
    exp_addr[3] = 22'h1; exp_addr[4] = 22'h2; exp_addr[5] = 22'h3;
    do_reset();
    ack_dly = 2;
    for (int p = 1; p < NP; p++) set_port(p, 1'b0, 22'(p), 16'h0);
    repeat (26) @(negedge clk);
    p_req = '0;
    repeat (20) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      n_tests++;
      if (ev_q.size() <= i || ev_q[i].is_ref || ev_q[i].addr !== exp_addr[i]) begin
        n_fail++; $display("FAIL rr_grant_%0d got addr=%h want %h", i, ev_q[i].addr, exp_addr[i]);
      end
    end
  endtask

  task automatic test_refresh_idle();
    do_reset();
    ack_dly = 2;
    repeat (2 * RI + 12) @(negedge clk);
    n_tests++; if (ev_q.size() != 2 || !ev_q[0].is_ref || !ev_q[1].is_ref) begin n_fail++;
      $display("FAIL refresh_count got %0d events want 2 refreshes", ev_q.size()); end
    n_tests++; if (ev_q.size() < 1 || ev_q[0].t - t0 != RI + 1) begin n_fail++;
      $display("FAIL refresh_first_time got %0d want %0d", ev_q[0].t - t0, RI + 1); end
    n_tests++; if (ev_q.size() < 2 || ev_q[1].t - ev_q[0].t != RI) begin n_fail++;
      $display("FAIL refresh_spacing got %0d want %0d", ev_q[1].t - ev_q[0].t, RI); end
  endtask

  task automatic test_urgent();
    int r = -1;
    do_reset();
    ack_dly = 2;
    set_port(0, 1'b0, 22'h3AA, 16'h0);
    repeat (150) @(negedge clk);
    p_req = '0;
    repeat (10) @(negedge clk);
    for (int i = 0; i < ev_q.size(); i++) if (r < 0 && ev_q[i].is_ref) r = i;
    n_tests++; if (r < 1) begin n_fail++;
      $display("FAIL urgent_found got index %0d want >=1", r); end
    n_tests++;
    if (r < 0 || ev_q[r].t - t0 < 2 * RI + 1 || ev_q[r].t - t0 > 2 * RI + 5) begin
      n_fail++; $display("FAIL urgent_time got %0d want %0d..%0d",
                         (r < 0) ? -1 : ev_q[r].t - t0, 2 * RI + 1, 2 * RI + 5); end
    n_tests++;
    if (r < 0 || ev_q.size() <= r + 1 || ev_q[r+1].is_ref || ev_q[r+1].addr !== 22'h3AA ||
        ev_q[r+1].t - ev_q[r].t != 4) begin
      n_fail++; $display("FAIL urgent_port0_next got size=%0d idx=%0d want port0 access 4 later",
                         ev_q.size(), r); end
  endtask

  task automatic test_overflow();
    do_reset();
    set_port(0, 1'b1, 22'h5, 16'h5555);
    @(negedge clk);
    p_req = '0;
    set_port(1, 1'b0, 22'h10, 16'h0);
    @(negedge clk);
    p_req = '0;
    set_port(1, 1'b0, 22'h20, 16'h0);
    @(negedge clk);
    p_req = '0;
    repeat (20) @(negedge clk);
    n_tests++; if (p_overflow !== 4'b0010) begin n_fail++;
      $display("FAIL ovf_flag got %b want 0010", p_overflow); end
    n_tests++; if (ev_q.size() != 2) begin n_fail++;
      $display("FAIL ovf_req_count got %0d want 2", ev_q.size()); end
    n_tests++; if (ev_q.size() < 2 || ev_q[1].addr !== 22'h20) begin n_fail++;
      $display("FAIL ovf_addr got %h want 000020", ev_q[1].addr); end
    n_tests++; if (ack_q.size() != 2) begin n_fail++;
      $display("FAIL ovf_ack_count got %0d want 2", ack_q.size()); end
  endtask

  task automatic test_reset_mid_busy();
    bit seen = 1'b0;
    do_reset();
    rd_data = 16'hCAFE;
    set_port(1, 1'b0, 22'h33, 16'h0);
    @(negedge clk);
    p_req = '0;
    repeat (10) @(negedge clk);
    n_tests++; if (p_data_read !== 16'hCAFE) begin n_fail++;
      $display("FAIL midrst_pre_data got %h want cafe", p_data_read); end
    rsp_en = 1'b0;
    set_port(1, 1'b0, 22'h44, 16'h0);
    @(negedge clk);
    p_req = '0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (mem_req) seen = 1'b1;
    end
    n_tests++; if (!seen) begin n_fail++;
      $display("FAIL midrst_req_seen got 0 want 1"); end
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    n_tests++; if ({p_ack, p_overflow, mem_req, mem_refresh} !== '0) begin n_fail++;
      $display("FAIL midrst_strobes got %h want 0", {p_ack, p_overflow, mem_req, mem_refresh}); end
    n_tests++; if ({mem_we, mem_wm, mem_address, mem_data_write, p_data_read} !== '0) begin
      n_fail++; $display("FAIL midrst_fields got addr=%h data_read=%h want 0",
                         mem_address, p_data_read); end
    ev_q.delete();
    ack_q.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    rsp_en  = 1'b1;
    repeat (12) @(negedge clk);
    n_tests++; if (ack_q.size() != 0) begin n_fail++;
      $display("FAIL midrst_stray_ack got %0d want 0", ack_q.size()); end
    n_tests++; if (ev_q.size() != 0) begin n_fail++;
      $display("FAIL midrst_reissue got %0d want 0", ev_q.size()); end
  endtask

  initial begin
    reset_n = 1'b0;
    clear_inputs();
    test_reset();
    test_single_read();
    test_priority();
    test_round_robin();
    test_refresh_idle();
    test_urgent();
    test_overflow();
    test_reset_mid_busy();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
